// File: rtl/branch_predictor.sv
// Decoded-op type shared with the control unit, plus a 2-bit saturating-counter
// branch direction predictor with branch/misprediction performance counters.

package control_unit_types_pkg;
  typedef enum logic [3:0] {
    ADDU = 4'd0,
    SUBU = 4'd1,
    ANDR = 4'd2,
    ORR  = 4'd3,
    SLT  = 4'd4,
    LW   = 4'd5,
    SW   = 4'd6,
    BEQ  = 4'd7,
    BNE  = 4'd8,
    J    = 4'd9,
    JAL  = 4'd10,
    JR   = 4'd11,
    LUI  = 4'd12,
    HALT = 4'd13
  } opfunc_t;
endpackage

module branch_predictor
  import control_unit_types_pkg::*;
#(
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [INDEX_W-1:0] ifprindex,
  output logic              PRresult,
  input  logic [INDEX_W-1:0] mmprindex,
  input  opfunc_t           opfunc,
  input  logic              ABtaken,
  input  logic              mmen,
  input  logic              mmpred,
  output logic [PERF_W-1:0] brcount,
  output logic [PERF_W-1:0] mispcount
);

  localparam int unsigned DEPTH = 2 ** INDEX_W;
  localparam logic [CNT_W-1:0] WNT     = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  logic [CNT_W-1:0]  r_table [DEPTH];
  logic [PERF_W-1:0] r_brcount;
  logic [PERF_W-1:0] r_mispcount;

  logic              w_is_branch;
  logic              w_upd;
  logic [CNT_W-1:0]  w_cur;
  logic [CNT_W-1:0]  w_next;

  // Update qualifier and saturating next value for the entry being trained
  always_comb begin
    w_is_branch = 1'b0;
    w_upd       = 1'b0;
    w_cur       = r_table[mmprindex];
    w_next      = w_cur;
    if ((opfunc == BEQ) || (opfunc == BNE)) begin
      w_is_branch = 1'b1;
    end
    w_upd = mmen & w_is_branch;
    if (ABtaken) begin
      if (w_cur != CNT_MAX) begin
        w_next = w_cur + CNT_W'(1);
      end
    end else begin
      if (w_cur != CNT_MIN) begin
        w_next = w_cur - CNT_W'(1);
      end
    end
  end

  // Counter table: one entry trained per qualified cycle, async clear to WNT
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_table[i] <= WNT;
      end
    end else if (w_upd) begin
      r_table[mmprindex] <= w_next;
    end
  end

  // Performance counters, wrapping modulo 2**PERF_W
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_brcount   <= '0;
      r_mispcount <= '0;
    end else if (w_upd) begin
      r_brcount <= r_brcount + PERF_W'(1);
      if (mmpred != ABtaken) begin
        r_mispcount <= r_mispcount + PERF_W'(1);
      end
    end
  end

  // Lookup is combinational from the registered table (no bypass on collision)
  assign PRresult  = r_table[ifprindex][CNT_W-1];
  assign brcount   = r_brcount;
  assign mispcount = r_mispcount;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed steps followed by random traffic,
// checked against a table-of-integers reference model.

module tb_branch_predictor;
  import control_unit_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic [1:0]  ifprindex;
  logic [1:0]  mmprindex;
  opfunc_t     opfunc;
  logic        ABtaken;
  logic        mmen;
  logic        mmpred;
  logic        PRresult;
  logic        PRresult4;
  logic [31:0] brcount;
  logic [31:0] mispcount;
  logic [3:0]  brcount4;
  logic [3:0]  mispcount4;

  int n_tests;
  int n_fail;

  // Reference model: counter values 0..3, prediction = value >= 2
  int unsigned m_tbl [4];
  int unsigned m_br;
  int unsigned m_misp;

  branch_predictor #(.INDEX_W(2), .CNT_W(2), .PERF_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ifprindex(ifprindex), .PRresult(PRresult),
    .mmprindex(mmprindex), .opfunc(opfunc), .ABtaken(ABtaken), .mmen(mmen),
    .mmpred(mmpred), .brcount(brcount), .mispcount(mispcount)
  );

  branch_predictor #(.INDEX_W(2), .CNT_W(2), .PERF_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ifprindex(ifprindex), .PRresult(PRresult4),
    .mmprindex(mmprindex), .opfunc(opfunc), .ABtaken(ABtaken), .mmen(mmen),
    .mmpred(mmpred), .brcount(brcount4), .mispcount(mispcount4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tbl[i] = 1;
    m_br   = 0;
    m_misp = 0;
  endtask

  function automatic logic model_pred(input int unsigned idx);
    return (m_tbl[idx] >= 2) ? 1'b1 : 1'b0;
  endfunction

  // One cycle: drive, check the pre-edge prediction, clock, update model, check counters
  task automatic step(input int unsigned ifi, input int unsigned mmi, input opfunc_t op,
                      input logic taken, input logic en, input logic pred);
    ifprindex = 2'(ifi);
    mmprindex = 2'(mmi);
    opfunc    = op;
    ABtaken   = taken;
    mmen      = en;
    mmpred    = pred;
    #1;
    check("pred", 32'(PRresult), 32'(model_pred(ifi)));
    check("pred4", 32'(PRresult4), 32'(model_pred(ifi)));
    @(posedge CLK);
    #1;
    if (en && (op == BEQ || op == BNE)) begin
      if (taken) m_tbl[mmi] = (m_tbl[mmi] == 3) ? 3 : m_tbl[mmi] + 1;
      else       m_tbl[mmi] = (m_tbl[mmi] == 0) ? 0 : m_tbl[mmi] - 1;
      m_br++;
      if (pred != taken) m_misp++;
    end
    check("brcount", brcount, m_br);
    check("mispcount", mispcount, m_misp);
    check("brcount4", 32'(brcount4), m_br % 16);
    check("mispcount4", 32'(mispcount4), m_misp % 16);
  endtask

  // Read every entry's prediction without training
  task automatic scan_table();
    for (int i = 0; i < 4; i++) step(i, 0, ADDU, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    nRST = 1'b0;
    ifprindex = '0; mmprindex = '0; opfunc = ADDU;
    ABtaken = 1'b0; mmen = 1'b0; mmpred = 1'b0;

    // Reset state
    #12;
    check("rst_brcount", brcount, 32'd0);
    check("rst_mispcount", mispcount, 32'd0);
    check("rst_brcount4", 32'(brcount4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ifprindex = 2'(i);
      #1;
      check("rst_pred", 32'(PRresult), 32'd0);
    end
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Index 2: three taken BEQ, all mispredicted
    for (int k = 0; k < 3; k++) step(2, 2, BEQ, 1'b1, 1'b1, 1'b0);
    check("idx2_st_pred_next", 32'(PRresult), 32'd1);
    check("idx2_brcount3", brcount, 32'd3);
    check("idx2_misp3", mispcount, 32'd3);

    // Index 2: two not-taken BNE, ST->WT keeps taken, WT->WNT flips
    step(2, 2, BNE, 1'b0, 1'b1, 1'b1);
    check("idx2_wt_pred", 32'(PRresult), 32'd1);
    step(2, 2, BNE, 1'b0, 1'b1, 1'b1);
    check("idx2_wnt_pred", 32'(PRresult), 32'd0);
    scan_table();

    // Collision at index 1: pre-update value in the cycle, new value after
    step(1, 1, BEQ, 1'b1, 1'b1, 1'b0);
    check("collide_next", 32'(PRresult), 32'd1);
    step(1, 0, ADDU, 1'b0, 1'b0, 1'b0);

    // Non-qualified traffic leaves everything unchanged
    step(1, 1, ADDU, 1'b0, 1'b1, 1'b1);
    step(1, 1, BEQ, 1'b0, 1'b0, 1'b1);
    step(1, 1, LW, 1'b0, 1'b1, 1'b0);
    scan_table();

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      int unsigned sel;
      opfunc_t op;
      sel = $urandom_range(0, 3);
      if (sel == 0)      op = BEQ;
      else if (sel == 1) op = BNE;
      else               op = opfunc_t'(4'($urandom_range(0, 13)));
      step($urandom_range(0, 3), $urandom_range(0, 3), op,
           1'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom));
    end

    // Train index 3 to ST, then async reset between clock edges
    for (int k = 0; k < 3; k++) step(3, 3, BEQ, 1'b1, 1'b1, 1'b1);
    ifprindex = 2'd3;
    mmprindex = 2'd3;
    opfunc = BEQ; ABtaken = 1'b1; mmen = 1'b1; mmpred = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    check("arst_pred", 32'(PRresult), 32'd0);
    check("arst_brcount", brcount, 32'd0);
    check("arst_mispcount", mispcount, 32'd0);
    check("arst_brcount4", 32'(brcount4), 32'd0);
    model_reset();
    #2;
    nRST = 1'b1;
    mmen = 1'b0;
    scan_table();
    // First training after reset starts from WNT
    step(0, 0, BNE, 1'b0, 1'b1, 1'b0);
    step(0, 0, BEQ, 1'b1, 1'b1, 1'b0);
    check("post_rst_pred0", 32'(PRresult), 32'd0);

    // Wrap: 17 more correctly-predicted branches on top of 2 -> 19
    for (int k = 0; k < 17; k++) begin
      logic t;
      int unsigned idx;
      t = 1'($urandom);
      idx = $urandom_range(0, 3);
      step(idx, idx, (k % 2 == 0) ? BEQ : BNE, t, 1'b1, t);
    end
    check("wrap_brcount4", 32'(brcount4), 32'd3);
    check("wrap_mispcount4", 32'(mispcount4), 32'd1);
    check("wrap_brcount", brcount, 32'd19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
